// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, I_ACC, D_ACC)
//   WIDTH_WORD  : byte width code driven on m_width for instruction fetches
//   is_access   : true while the FSM owns the memory port
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_I_ACC = 2'd1,
        ST_D_ACC = 2'd2
    } arb_state_t;

    // Instruction fetches are always full 32-bit words.
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    function automatic logic is_access(arb_state_t s);
        return (s == ST_I_ACC) || (s == ST_D_ACC);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port (i_*), data port (d_*), memory port (m_*), stalls
// and the timeout flag of the memory arbiter.
//
// Handshake: a requester raises i_req/d_req with stable address/data and
// keeps it up until it sees its single-cycle i_ack/d_ack; the arbiter
// raises m_req with stable m_* fields and holds them until it samples
// m_ack=1 (or its access timer expires), then drops m_req for at least one
// cycle before the next access.
//
// Modports:
//   slave  : the arbiter (consumes requests, drives memory port and acks)
//   master : the environment (CPU stages + memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_width;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              m_req;
    logic              m_we;
    logic [1:0]        m_width;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              stall_if;
    logic              stall_mem;
    logic              err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_width, d_addr, d_wdata,
               m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack,
               m_req, m_we, m_width, m_addr, m_wdata,
               stall_if, stall_mem, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_width, d_addr, d_wdata,
               m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack,
               m_req, m_we, m_width, m_addr, m_wdata,
               stall_if, stall_mem, err
    );

endinterface

// File: rtl/acc_timer.sv
// ---------------------------------------------------------------------------
// acc_timer
// Counts cycles of one memory access and flags when the access has used
// up its budget.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   clear_i    : restart the count at 0 (access entry)
//   enable_i   : count this cycle
//   expired_o  : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module acc_timer #(
    parameter  int TIMEOUT = 16,
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (clear_i) begin
            tcnt_d = '0;
        end else if (enable_i) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign expired_o = (tcnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares a single memory port between the instruction-fetch and data
// requesters. Data wins by default, but after MAX_STREAK consecutive data
// grants made while a fetch was waiting the fetch is served. Each access
// is bounded by TIMEOUT cycles; an expired access completes with rdata=0
// and a one-cycle err pulse.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : fetch / data / memory ports, stalls, err (slave modport)
//   dbg_state_o  : current FSM state
//   dbg_streak_o : current data-grant streak count
// ---------------------------------------------------------------------------
module mem_arbiter
    import mips_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int MAX_STREAK = 4,
    parameter  int TIMEOUT    = 16,
    localparam int STREAK_W   = $clog2(MAX_STREAK + 1)
) (
    input  logic                clk,
    input  logic                reset,
    mem_arbiter_if.slave        bus,
    output arb_state_t          dbg_state_o,
    output logic [STREAK_W-1:0] dbg_streak_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    arb_state_t        state_q,   state_d;
    logic              m_req_q,   m_req_d;
    logic              m_we_q,    m_we_d;
    logic [1:0]        m_width_q, m_width_d;
    logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q,   i_ack_d;
    logic              d_ack_q,   d_ack_d;
    logic              err_q,     err_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    acc_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_acc_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_width_d  = m_width_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        streak_d   = streak_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Data is preferred unless a waiting fetch has been passed
                // over MAX_STREAK times in a row.
                if (bus.d_req && !(bus.i_req && (streak_q >= STREAK_MAX))) begin
                    state_d   = ST_D_ACC;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_width_d = bus.d_width;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    tmr_clear = 1'b1;
                    if (!bus.i_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (bus.i_req) begin
                    state_d   = ST_I_ACC;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_width_d = WIDTH_WORD;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    tmr_clear = 1'b1;
                    streak_d  = '0;
                end
            end

            ST_I_ACC, ST_D_ACC: begin
                // m_ack takes priority over an expiring timer on the same cycle.
                if (bus.m_ack || tmr_expired) begin
                    state_d = ST_IDLE;
                    m_req_d = 1'b0;
                    err_d   = !bus.m_ack;
                    if (state_q == ST_I_ACC) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.m_ack ? bus.m_rdata : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = bus.m_ack ? bus.m_rdata : '0;
                    end
                end else begin
                    tmr_enable = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_width_q <= 2'b00;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            streak_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_width_q <= m_width_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            streak_q  <= streak_d;
        end
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_width   = m_width_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.i_req & ~i_ack_q;
    assign bus.stall_mem = bus.d_req & ~d_ack_q;

    assign dbg_state_o  = state_q;
    assign dbg_streak_o = streak_q;

endmodule
